led_fader: RTL and testbench

- Downstream stage of the LED rotation counter.
- Takes per-LED logic levels (rotation bits plus flow flag) and drives each LED pad with a PWM signal.
- Brightness ramps linearly toward the requested level instead of switching hard.
- Sits between the rotation/pattern logic and the D1..D5 pads; single 12 MHz clock domain.

---
 rtl/led_pkg.sv | 26 ++
 rtl/led_fade_chan.sv | 59 +++++
 rtl/led_fader.sv | 62 ++++++
 tb/tb_led_fader.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants and types for the LED fade/PWM stage.
// Channel state is derived from brightness and requested level, never stored.
package led_pkg;

   localparam int CLK_HZ        = 12000000;
   localparam int N_LED         = 5;
   localparam int PWM_BITS      = 8;
   localparam int FADE_STEP_DIV = 23438;

   typedef logic [PWM_BITS-1:0] bright_t;

   typedef enum logic [1:0] {
      CH_OFF,
      CH_RISING,
      CH_ON,
      CH_FALLING
   } chan_state_e;

   function automatic chan_state_e chan_state(input logic level,
                                              input logic at_zero,
                                              input logic at_max);
      if (level) return at_max ? CH_ON : CH_RISING;
      else       return at_zero ? CH_OFF : CH_FALLING;
   endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One LED channel: saturating brightness ramp, PWM compare and settled flag.
// Brightness keeps tracking in bypass so PWM resumes from the current level.
module led_fade_chan #(
   parameter int PWM_BITS = led_pkg::PWM_BITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                level,
   input  logic                bypass,
   output logic                led_out,
   output logic                settled,
   output logic                unsettled_next
);
   import led_pkg::*;

   localparam logic [PWM_BITS-1:0] MAX = '1;

   logic [PWM_BITS-1:0] b_q, b_d;
   logic                led_q, led_d;
   logic                settled_q, settled_d;
   chan_state_e         state;

   always_comb begin
      state = chan_state(level, b_q == '0, b_q == MAX);

      b_d = b_q;
      if (tick) begin
         case (state)
            CH_RISING:  b_d = b_q + 1'b1;
            CH_FALLING: b_d = b_q - 1'b1;
            default:    b_d = b_q;
         endcase
      end

      // Full brightness forces a constant 1; a plain compare would drop one slot per period.
      led_d     = bypass ? level : ((b_q == MAX) || (pwm_cnt < b_q));
      settled_d = (state == CH_OFF) || (state == CH_ON);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q       <= '0;
         led_q     <= 1'b0;
         settled_q <= 1'b1;
      end else begin
         b_q       <= b_d;
         led_q     <= led_d;
         settled_q <= settled_d;
      end
   end

   assign led_out        = led_q;
   assign settled        = settled_q;
   assign unsettled_next = ~settled_d;

endmodule

// File: rtl/led_fader.sv
// LED pad driver: shared step prescaler and PWM counter feeding N_LED fade channels.
// Outputs are registered; reset clears all brightness and forces the pads low.
module led_fader #(
   parameter int N_LED    = led_pkg::N_LED,
   parameter int PWM_BITS = led_pkg::PWM_BITS,
   parameter int STEP_DIV = led_pkg::FADE_STEP_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_LED-1:0] level_in,
   input  logic             bypass,
   output logic [N_LED-1:0] led_out,
   output logic [N_LED-1:0] settled,
   output logic             busy
);
   localparam int                PRESC_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic                busy_q, busy_d;
   logic                tick;
   logic [N_LED-1:0]    unsettled_next;

   always_comb begin
      tick      = (presc_q == PRESC_LAST);
      presc_d   = tick ? '0 : presc_q + 1'b1;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      busy_d    = |unsettled_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         pwm_cnt_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         pwm_cnt_q <= pwm_cnt_d;
         busy_q    <= busy_d;
      end
   end

   for (genvar i = 0; i < N_LED; i++) begin : g_chan
      led_fade_chan #(
         .PWM_BITS (PWM_BITS)
      ) u_chan (
         .clk            (clk),
         .rst_n          (rst_n),
         .tick           (tick),
         .pwm_cnt        (pwm_cnt_q),
         .level          (level_in[i]),
         .bypass         (bypass),
         .led_out        (led_out[i]),
         .settled        (settled[i]),
         .unsettled_next (unsettled_next[i])
      );
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader with small parameters (3-bit PWM, step every 4 clocks).
// Reference model works from cycle count since reset and saturating brightness arithmetic.
module tb_led_fader;

   localparam int N   = 2;
   localparam int PB  = 3;
   localparam int DIV = 4;
   localparam int MAXB = (1 << PB) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] level_in = '0;
   logic         bypass = 1'b0;
   logic [N-1:0] led_out;
   logic [N-1:0] settled;
   logic         busy;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int           mb [N];
   int           mn;
   logic [N-1:0] e_led;
   logic [N-1:0] e_set;
   logic         e_busy;

   led_fader #(
      .N_LED    (N),
      .PWM_BITS (PB),
      .STEP_DIV (DIV)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .level_in (level_in),
      .bypass   (bypass),
      .led_out  (led_out),
      .settled  (settled),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, mn);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) mb[i] = 0;
      mn = 0;
   endtask

   // Outputs registered at clock edge number mn (counted from reset release).
   task automatic model_step();
      int  pwm;
      bit  tick;
      pwm  = mn % (1 << PB);
      tick = (mn % DIV) == DIV - 1;
      for (int i = 0; i < N; i++) begin
         if (bypass) e_led[i] = level_in[i];
         else        e_led[i] = (mb[i] == MAXB) || (pwm < mb[i]);
         e_set[i] = level_in[i] ? (mb[i] == MAXB) : (mb[i] == 0);
         if (tick) begin
            if (level_in[i]) mb[i] = (mb[i] < MAXB) ? mb[i] + 1 : MAXB;
            else             mb[i] = (mb[i] > 0) ? mb[i] - 1 : 0;
         end
      end
      e_busy = (e_set != {N{1'b1}});
      mn++;
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      @(negedge clk);
      check({tag, "_led"}, led_out, e_led);
      check({tag, "_settled"}, settled, e_set);
      check({tag, "_busy"}, busy, e_busy);
   endtask

   task automatic run(input int k, input string tag);
      for (int c = 0; c < k; c++) cycle(tag);
   endtask

   initial begin
      model_reset();

      // Reset state with reset held
      #12;
      check("reset_led", led_out, 0);
      check("reset_settled", settled, 2'b11);
      check("reset_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run(100, "idle");

      // Full rise on channel 0
      level_in[0] = 1'b1;
      run(40, "rise");
      check("full_on_led", led_out[0], 1);
      check("full_on_settled", settled[0], 1);

      // Full fall back to zero
      level_in[0] = 1'b0;
      run(40, "fall");
      check("full_off_led", led_out[0], 0);

      // Reverse at b0=4 while rising
      level_in[0] = 1'b1;
      for (int c = 0; c < 100 && mb[0] != 4; c++) cycle("rise_to4");
      level_in[0] = 1'b0;
      run(30, "reverse");

      // Toggle level exactly on tick cycles
      for (int k = 0; k < 6; k++) begin
         for (int c = 0; c < DIV && (mn % DIV) != DIV - 1; c++) cycle("pre_tick");
         level_in = level_in ^ 2'(1 + (k % 3));
         cycle("tick_toggle");
      end
      run(20, "post_toggle");

      // Bypass mid-ramp
      level_in = 2'b01;
      run(10, "pre_bypass");
      bypass = 1'b1;
      for (int c = 0; c < 24; c++) begin
         if (c % 5 == 2) level_in[1] = ~level_in[1];
         cycle("bypass");
      end
      bypass = 1'b0;
      run(24, "post_bypass");

      // Randomized levels with occasional bypass
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 11) == 0) level_in = N'($urandom_range(0, (1 << N) - 1));
         if ($urandom_range(0, 29) == 0) bypass = ~bypass;
         cycle("random");
      end
      bypass = 1'b0;

      // Asynchronous reset mid-ramp at b0=5
      level_in = 2'b00;
      run(40, "drain");
      level_in[0] = 1'b1;
      for (int c = 0; c < 100 && mb[0] != 5; c++) cycle("rise_to5");
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_led", led_out, 0);
      check("async_rst_settled", settled, 2'b11);
      check("async_rst_busy", busy, 0);
      model_reset();
      @(negedge clk);
      check("in_rst_led", led_out, 0);
      rst_n = 1'b1;
      run(40, "restart");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
